dpram_pipe: RTL and testbench

//   Parametrised simple dual-port RAM (one write port, one read port, one clock) for router packet buffers.

---
 rtl/dpram_pipe.sv | 111 +++++++++++
 tb/tb_dpram_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_pipe.sv
// Simple dual-port packet-buffer RAM with byte-lane writes, a 1- or 2-stage read pipeline
// and a same-address read-during-write policy that raises a collision flag alongside the read.
module dpram_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]            addr_wr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            addr_rd,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             collision
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dpram_pipe: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dpram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_hit;

    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_coll;

    // The array itself is deliberately left out of reset so buffered packets survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[addr_wr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        old_word    = mem[addr_rd];
        merged_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // An all-zero byte mask is not a write, so it can never collide.
    assign wr_hit  = wr_en & (|wr_be) & (addr_rd == addr_wr);
    assign rd_word = (RDW_MODE == 1 && wr_hit) ? merged_word : old_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            s1_coll  <= rd_en & wr_hit;
            if (rd_en) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;
        logic                  s2_coll;

        // Data is frozen at the request edge; later writes are not forwarded into this stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
                s2_coll  <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                s2_coll  <= s1_coll;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign data_out  = s2_data;
        assign rd_valid  = s2_valid;
        assign collision = s2_coll;
    end else begin : g_lat1
        assign data_out  = s1_data;
        assign rd_valid  = s1_valid;
        assign collision = s1_coll;
    end

endmodule

// File: tb/tb_dpram_pipe.sv
// Directed bench for dpram_pipe: four instances cover RD_LATENCY 1/2 x RDW_MODE 0/1 on shared stimulus.
// Instance k uses RD_LATENCY = k/2+1 and RDW_MODE = k%2.
module tb_dpram_pipe;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [3:0]  addr_wr;
    logic [31:0] data_in;
    logic        rd_en;
    logic [3:0]  addr_rd;
    logic [31:0] dout [4];
    logic        rv   [4];
    logic        col  [4];

    int checks;
    int errors;

    // Expected latency-1 outputs after the most recent edge; latency-2 sees the same one edge later.
    logic        l1_v, l1_c, l2_v, l2_c;
    logic [31:0] l1_d0, l1_d1, l2_d0, l2_d1;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        dpram_pipe #(
            .DATA_WIDTH(32),
            .BYTE_WIDTH(8),
            .ADDR_WIDTH(4),
            .RD_LATENCY(k / 2 + 1),
            .RDW_MODE  (k % 2)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en),
            .wr_be    (wr_be),
            .addr_wr  (addr_wr),
            .data_in  (data_in),
            .rd_en    (rd_en),
            .addr_rd  (addr_rd),
            .data_out (dout[k]),
            .rd_valid (rv[k]),
            .collision(col[k])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_d(int k);
        if (k < 2) return (k % 2 == 1) ? l1_d1 : l1_d0;
        return (k % 2 == 1) ? l2_d1 : l2_d0;
    endfunction

    function automatic logic exp_v(int k);
        return (k < 2) ? l1_v : l2_v;
    endfunction

    function automatic logic exp_c(int k);
        return (k < 2) ? l1_c : l2_c;
    endfunction

    // Presents one cycle of stimulus from a falling edge and advances the expectations;
    // ed0/ed1 are the hand-computed read results for RDW_MODE 0/1.
    task automatic drive(input logic re, input logic [3:0] ar, input logic we,
                         input logic [3:0] be, input logic [3:0] aw, input logic [31:0] din,
                         input logic [31:0] ed0, input logic [31:0] ed1, input logic ec);
        rd_en   = re;
        addr_rd = ar;
        wr_en   = we;
        wr_be   = be;
        addr_wr = aw;
        data_in = din;
        @(posedge clk);
        l2_v  = l1_v;
        l2_d0 = l1_d0;
        l2_d1 = l1_d1;
        l2_c  = l1_c;
        if (re) begin
            l1_v  = 1'b1;
            l1_d0 = ed0;
            l1_d1 = ed1;
            l1_c  = ec;
        end else begin
            l1_v = 1'b0;
            l1_c = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic clear_expect();
        l1_v = 0; l1_c = 0; l1_d0 = 0; l1_d1 = 0;
        l2_v = 0; l2_c = 0; l2_d0 = 0; l2_d1 = 0;
    endtask

    task automatic test_reset();
        clear_expect();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'd0 || rv[k] !== 1'b0 || col[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset inst%0d: data=%h valid=%b coll=%b, required data=0 valid=0 coll=0",
                         k, dout[k], rv[k], col[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_read();
        for (int c = 0; c < 34; c++) begin
            if (c < 16)
                drive(1'b0, 4'd0, 1'b1, 4'hF, 4'(c), 32'hA5A5_0000 + c, 32'd0, 32'd0, 1'b0);
            else if (c < 32)
                drive(1'b1, 4'(c - 16), 1'b0, 4'd0, 4'd0, 32'd0,
                      32'hA5A5_0000 + (c - 16), 32'hA5A5_0000 + (c - 16), 1'b0);
            else
                idle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL fill_read inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(1'b0, 4'd0, 1'b1, 4'hF, 4'd3, 32'h1122_3344, 32'd0, 32'd0, 1'b0);
                1: drive(1'b0, 4'd0, 1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 32'd0, 32'd0, 1'b0);
                2: drive(1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 32'd0, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0);
                default: idle();
            endcase
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL byte_enable inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(1'b0, 4'd0, 1'b1, 4'hF, 4'd5, 32'h0000_0000, 32'd0, 32'd0, 1'b0);
                1: drive(1'b1, 4'd5, 1'b1, 4'b1100, 4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_0000, 1'b1);
                2: drive(1'b1, 4'd5, 1'b0, 4'd0, 4'd0, 32'd0, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0);
                default: idle();
            endcase
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL collision inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    task automatic test_no_collision();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(1'b1, 4'd7, 1'b1, 4'b0000, 4'd7, 32'hFFFF_FFFF, 32'hA5A5_0007, 32'hA5A5_0007, 1'b0);
                1: drive(1'b1, 4'd7, 1'b1, 4'hF, 4'd6, 32'h1234_5678, 32'hA5A5_0007, 32'hA5A5_0007, 1'b0);
                2: drive(1'b1, 4'd6, 1'b0, 4'd0, 4'd0, 32'd0, 32'h1234_5678, 32'h1234_5678, 1'b0);
                default: idle();
            endcase
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL no_collision inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    task automatic test_reset_midpipe();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0);
        rd_en   = 1'b1;
        addr_rd = 4'd2;
        @(posedge clk);
        #2 rst_n = 1'b0;
        rd_en = 1'b0;
        clear_expect();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'd0 || rv[k] !== 1'b0 || col[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_midpipe inst%0d: data=%h valid=%b coll=%b, required data=0 valid=0 coll=0",
                         k, dout[k], rv[k], col[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3)
                drive(1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 32'd0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0);
            else
                idle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL after_reset inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    task automatic test_single_pulse();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)
                drive(1'b1, 4'd9, 1'b0, 4'd0, 4'd0, 32'd0, 32'hA5A5_0009, 32'hA5A5_0009, 1'b0);
            else
                idle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== exp_d(k) || rv[k] !== exp_v(k) || col[k] !== exp_c(k)) begin
                    errors++;
                    $display("[TB] FAIL single_pulse inst%0d cyc%0d: data=%h valid=%b coll=%b, required data=%h valid=%b coll=%b",
                             k, c, dout[k], rv[k], col[k], exp_d(k), exp_v(k), exp_c(k));
                end
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        wr_en   = 1'b0;
        wr_be   = 4'd0;
        addr_wr = 4'd0;
        data_in = 32'd0;
        rd_en   = 1'b0;
        addr_rd = 4'd0;
        test_reset();
        test_fill_read();
        test_byte_enable();
        test_collision();
        test_no_collision();
        test_reset_midpipe();
        test_single_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
